// File: rtl/array_pkg.sv
// Shared array frame layout, width defaults and arbiter state encoding.
// Pure definitions: no latency, no backpressure.
package array_pkg;

    localparam int ARRAY_COL_ADDR_W = 6;
    localparam int ARRAY_ROW_ADDR_W = 16;
    localparam int ARRAY_DATA_W     = 64;
    localparam int ARRAY_FRAME_W    = 3 + ARRAY_COL_ADDR_W + ARRAY_ROW_ADDR_W + ARRAY_DATA_W;

    // State values double as the arb_owner encoding (00 none, 01 write, 10 read).
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WR_LOCK = 2'b01,
        RD_LOCK = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWNER_WR = 1'b0,
        OWNER_RD = 1'b1
    } arb_owner_t;

    // Frame layout at default widths, MSB first: eof, sof, rw, data, raddr, caddr.
    typedef struct packed {
        logic                        eof;
        logic                        sof;
        logic                        rw;
        logic [ARRAY_DATA_W-1:0]     data;
        logic [ARRAY_ROW_ADDR_W-1:0] raddr;
        logic [ARRAY_COL_ADDR_W-1:0] caddr;
    } array_frame_t;

    // Flag bits sit directly above the address and data fields.
    function automatic int frame_rw_bit(input int col_w, input int row_w, input int data_w);
        return col_w + row_w + data_w;
    endfunction

    function automatic int frame_sof_bit(input int col_w, input int row_w, input int data_w);
        return col_w + row_w + data_w + 1;
    endfunction

    function automatic int frame_eof_bit(input int col_w, input int row_w, input int data_w);
        return col_w + row_w + data_w + 2;
    endfunction

endpackage

// File: rtl/array_frame_reg.sv
// Valid/ready pipeline register for the arbitrated frame stream; 1-cycle latency.
// Backpressure: load_en = !valid || ready, so it streams at full rate and holds data while stalled.
module array_frame_reg
    import array_pkg::*;
#(
    parameter int WIDTH = ARRAY_FRAME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_valid,
    input  logic [WIDTH-1:0] beat_data,
    output logic             load_en,
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame_data,
    input  logic             frame_ready
);

    assign load_en = !frame_valid || frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (load_en) begin
            frame_valid <= beat_valid;
            if (beat_valid) begin
                frame_data <= beat_data;
            end
        end
    end

endmodule

// File: rtl/array_frame_arb.sv
// Whole-frame arbiter between write and read requesters into one registered stream; 1-cycle latency.
// Backpressure: only the granted requester sees ready, and only while the output register can load.
module array_frame_arb
    import array_pkg::*;
#(
    parameter int ARRAY_COL_ADDR_WIDTH   = ARRAY_COL_ADDR_W,
    parameter int ARRAY_ROW_ADDR_WIDTH   = ARRAY_ROW_ADDR_W,
    parameter int ARRAY_DATA_WIDTH       = ARRAY_DATA_W,
    parameter int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mc_en,
    input  logic                              wr_frame_valid,
    input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] wr_frame_data,
    output logic                              wr_frame_ready,
    input  logic                              rd_frame_valid,
    input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] rd_frame_data,
    output logic                              rd_frame_ready,
    output logic                              axi2array_frame_valid,
    output logic [ARRAY_FRAME_DATA_WIDTH-1:0] axi2array_frame_data,
    input  logic                              axi2array_frame_ready,
    output logic [1:0]                        arb_owner,
    output logic                              arb_proto_err
);

    localparam int RW_BIT  = frame_rw_bit(ARRAY_COL_ADDR_WIDTH, ARRAY_ROW_ADDR_WIDTH, ARRAY_DATA_WIDTH);
    localparam int SOF_BIT = frame_sof_bit(ARRAY_COL_ADDR_WIDTH, ARRAY_ROW_ADDR_WIDTH, ARRAY_DATA_WIDTH);
    localparam int EOF_BIT = frame_eof_bit(ARRAY_COL_ADDR_WIDTH, ARRAY_ROW_ADDR_WIDTH, ARRAY_DATA_WIDTH);

    arb_state_t state;
    arb_state_t state_nxt;
    arb_owner_t last_owner;
    arb_owner_t last_owner_nxt;

    logic                              arb_run;
    logic                              load_en;
    logic                              grant_wr;
    logic                              grant_rd;
    logic                              wr_acc;
    logic                              rd_acc;
    logic                              beat_valid;
    logic [ARRAY_FRAME_DATA_WIDTH-1:0] beat_data;
    logic                              err_set;

    // Readies stay low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_run <= 1'b0;
        end else begin
            arb_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_owner    <= OWNER_RD;
            arb_proto_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            if (err_set) begin
                arb_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;

        unique case (state)
            IDLE: begin
                // Tie goes to whichever requester did not finish the previous frame.
                if (mc_en && load_en) begin
                    if (wr_frame_valid && (!rd_frame_valid || last_owner == OWNER_RD)) begin
                        grant_wr = 1'b1;
                    end else if (rd_frame_valid) begin
                        grant_rd = 1'b1;
                    end
                end
            end
            WR_LOCK: grant_wr = load_en;
            RD_LOCK: grant_rd = load_en;
            default: state_nxt = IDLE;
        endcase

        wr_frame_ready = grant_wr && arb_run;
        rd_frame_ready = grant_rd && arb_run;
        wr_acc         = wr_frame_valid && wr_frame_ready;
        rd_acc         = rd_frame_valid && rd_frame_ready;

        if (wr_acc) begin
            if (wr_frame_data[EOF_BIT]) begin
                state_nxt      = IDLE;
                last_owner_nxt = OWNER_WR;
            end else begin
                state_nxt = WR_LOCK;
            end
        end else if (rd_acc) begin
            if (rd_frame_data[EOF_BIT]) begin
                state_nxt      = IDLE;
                last_owner_nxt = OWNER_RD;
            end else begin
                state_nxt = RD_LOCK;
            end
        end

        beat_valid = wr_acc || rd_acc;
        beat_data  = wr_acc ? wr_frame_data : rd_frame_data;

        // Offending beats are flagged but still forwarded unchanged.
        err_set = (wr_acc && !wr_frame_data[RW_BIT])
               || (rd_acc && rd_frame_data[RW_BIT])
               || (beat_valid && state != IDLE && beat_data[SOF_BIT]);
    end

    assign arb_owner = state;

    array_frame_reg #(
        .WIDTH (ARRAY_FRAME_DATA_WIDTH)
    ) u_frame_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_valid  (beat_valid),
        .beat_data   (beat_data),
        .load_en     (load_en),
        .frame_valid (axi2array_frame_valid),
        .frame_data  (axi2array_frame_data),
        .frame_ready (axi2array_frame_ready)
    );

endmodule

// File: tb/tb_array_frame_arb.sv
// Bench for array_frame_arb: cycle table for arbitration basics, then queued multi-cycle sequences.
module tb_array_frame_arb;
    import array_pkg::*;

    localparam int FW = ARRAY_FRAME_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mc_en = 1'b0;
    logic          wr_frame_valid = 1'b0;
    logic [FW-1:0] wr_frame_data = '0;
    logic          wr_frame_ready;
    logic          rd_frame_valid = 1'b0;
    logic [FW-1:0] rd_frame_data = '0;
    logic          rd_frame_ready;
    logic          axi2array_frame_valid;
    logic [FW-1:0] axi2array_frame_data;
    logic          axi2array_frame_ready = 1'b1;
    logic [1:0]    arb_owner;
    logic          arb_proto_err;

    always #5 clk = ~clk;

    array_frame_arb dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mc_en                 (mc_en),
        .wr_frame_valid        (wr_frame_valid),
        .wr_frame_data         (wr_frame_data),
        .wr_frame_ready        (wr_frame_ready),
        .rd_frame_valid        (rd_frame_valid),
        .rd_frame_data         (rd_frame_data),
        .rd_frame_ready        (rd_frame_ready),
        .axi2array_frame_valid (axi2array_frame_valid),
        .axi2array_frame_data  (axi2array_frame_data),
        .axi2array_frame_ready (axi2array_frame_ready),
        .arb_owner             (arb_owner),
        .arb_proto_err         (arb_proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input bit sof, input bit eof, input bit rw, input int tag);
        array_frame_t f;
        f.eof   = eof;
        f.sof   = sof;
        f.rw    = rw;
        f.data  = 64'hC0DE_0000_0000_0000 | 64'(tag);
        f.raddr = 16'(tag) ^ 16'hA5A5;
        f.caddr = 6'(tag);
        return f;
    endfunction

    typedef struct {
        bit            mc;
        bit            wv;
        logic [FW-1:0] wd;
        bit            rv;
        logic [FW-1:0] rd;
        bit            ordy;
        bit            e_wr;
        bit            e_rd;
        bit            e_ov;
        logic [FW-1:0] e_od;
        logic [1:0]    e_own;
        bit            e_err;
    } vec_t;

    vec_t tbl[11];

    // Bench-side model and queues for the sequence tests.
    logic [FW-1:0] wr_q[$];
    logic [FW-1:0] rd_q[$];
    logic [FW-1:0] got_q[$];
    logic [FW-1:0] exp_q[$];
    bit            fire_log[$];
    bit            in_wr, in_rd, prev_stall;
    logic [FW-1:0] prev_data;
    int            rmode, cyc, wr_cnt, rd_cnt;

    task automatic clear_model();
        wr_q.delete(); rd_q.delete(); got_q.delete(); exp_q.delete(); fire_log.delete();
        in_wr = 0; in_rd = 0; prev_stall = 0; prev_data = '0;
        rmode = 0; cyc = 0; wr_cnt = 0; rd_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        mc_en = 1'b1;
        wr_frame_valid = 1'b0;
        rd_frame_valid = 1'b0;
        axi2array_frame_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input bit to_wr, input int n, input int tag0);
        for (int i = 0; i < n; i++) begin
            if (to_wr) wr_q.push_back(mk(i == 0, i == n - 1, 1'b1, tag0 + i));
            else       rd_q.push_back(mk(i == 0, i == n - 1, 1'b0, tag0 + i));
        end
    endtask

    task automatic add_exp(input bit rw, input int n, input int tag0);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(i == 0, i == n - 1, rw, tag0 + i));
    endtask

    task automatic step();
        @(negedge clk);
        wr_frame_valid = wr_q.size() > 0;
        wr_frame_data  = (wr_q.size() > 0) ? wr_q[0] : '0;
        rd_frame_valid = rd_q.size() > 0;
        rd_frame_data  = (rd_q.size() > 0) ? rd_q[0] : '0;
        axi2array_frame_ready = (rmode == 1) ? cyc[0] : 1'b1;
        #3;
        chk("owner", arb_owner, in_wr ? 2'b01 : (in_rd ? 2'b10 : 2'b00));
        chk("rdy_onehot", wr_frame_ready & rd_frame_ready, 0);
        if (!mc_en && !in_wr && !in_rd) chk("mc_en_block", {wr_frame_ready, rd_frame_ready}, 0);
        if (prev_stall) begin
            chk("stall_vld", axi2array_frame_valid, 1);
            chk("stall_dat", axi2array_frame_data, prev_data);
        end
        prev_stall = axi2array_frame_valid && !axi2array_frame_ready;
        prev_data  = axi2array_frame_data;
        fire_log.push_back(axi2array_frame_valid && axi2array_frame_ready);
        if (axi2array_frame_valid && axi2array_frame_ready) got_q.push_back(axi2array_frame_data);
        if (wr_frame_valid && wr_frame_ready) begin
            if (in_wr && wr_frame_data[FW-1]) in_wr = 0;
            else if (!in_wr && !wr_frame_data[FW-1]) in_wr = 1;
            void'(wr_q.pop_front());
            wr_cnt++;
        end
        if (rd_frame_valid && rd_frame_ready) begin
            if (in_rd && rd_frame_data[FW-1]) in_rd = 0;
            else if (!in_rd && !rd_frame_data[FW-1]) in_rd = 1;
            void'(rd_q.pop_front());
            rd_cnt++;
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic wait_got(input string name, input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) step();
        chk({name, "_count"}, got_q.size(), n);
    endtask

    task automatic cmp_seq(input string name);
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        end
    endtask

    initial begin
        logic [FW-1:0] w1, r2, w3, r4, w5, r6, r7, r8;
        logic [11:0]   fires;
        w1 = mk(1, 1, 1, 1); r2 = mk(1, 1, 0, 2); w3 = mk(1, 1, 1, 3); r4 = mk(1, 0, 0, 4);
        w5 = mk(1, 1, 1, 5); r6 = mk(0, 0, 0, 6); r7 = mk(1, 0, 0, 7); r8 = mk(0, 1, 0, 8);
        //           mc  wv  wd  rv  rd  ordy  e_wr e_rd e_ov e_od e_own  e_err
        tbl[0]  = '{1'b0, 1'b1, w1, 1'b1, r2, 1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, w1, 1'b1, r2, 1'b1, 1'b1, 1'b0, 1'b1, w1, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, w3, 1'b1, r2, 1'b1, 1'b0, 1'b1, 1'b1, r2, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, w3, 1'b1, r4, 1'b1, 1'b1, 1'b0, 1'b1, w3, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, w3, 1'b1, r4, 1'b1, 1'b0, 1'b1, 1'b1, r4, 2'b10, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, w5, 1'b1, r6, 1'b0, 1'b0, 1'b0, 1'b1, r4, 2'b10, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, w5, 1'b1, r6, 1'b1, 1'b0, 1'b1, 1'b1, r6, 2'b10, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, w5, 1'b1, r7, 1'b1, 1'b0, 1'b1, 1'b1, r7, 2'b10, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, w5, 1'b1, r8, 1'b1, 1'b0, 1'b1, 1'b1, r8, 2'b00, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, w5, 1'b0, r8, 1'b1, 1'b1, 1'b0, 1'b1, w5, 2'b00, 1'b1};
        tbl[10] = '{1'b1, 1'b0, w5, 1'b0, r8, 1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b1};

        // Reset state, with requesters already asserting valid.
        clear_model();
        mc_en = 1'b1; wr_frame_valid = 1'b1; wr_frame_data = w1; rd_frame_valid = 1'b1; rd_frame_data = r2;
        #1;
        chk("rst_vld", axi2array_frame_valid, 0);
        chk("rst_dat", axi2array_frame_data, 0);
        chk("rst_owner", arb_owner, 0);
        chk("rst_err", arb_proto_err, 0);
        chk("rst_rdy", {wr_frame_ready, rd_frame_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            mc_en = tbl[i].mc;
            wr_frame_valid = tbl[i].wv; wr_frame_data = tbl[i].wd;
            rd_frame_valid = tbl[i].rv; rd_frame_data = tbl[i].rd;
            axi2array_frame_ready = tbl[i].ordy;
            #3;
            chk($sformatf("v%0d_wr_rdy", i), wr_frame_ready, tbl[i].e_wr);
            chk($sformatf("v%0d_rd_rdy", i), rd_frame_ready, tbl[i].e_rd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ovld", i), axi2array_frame_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("v%0d_odat", i), axi2array_frame_data, tbl[i].e_od);
            chk($sformatf("v%0d_owner", i), arb_owner, tbl[i].e_own);
            chk($sformatf("v%0d_err", i), arb_proto_err, tbl[i].e_err);
        end

        // Lone 8-beat write: back-to-back output one cycle after each accept.
        do_reset();
        push_frame(1, 8, 100);
        add_exp(1, 8, 100);
        for (int k = 0; k < 12; k++) step();
        cmp_seq("s1");
        fires = '0;
        for (int i = 0; i < 12; i++) fires[i] = fire_log[i];
        chk("s1_fire_pattern", fires, 12'h1FE);
        chk("s1_owner_end", arb_owner, 0);

        // Simultaneous start: whole write frame, whole read frame, then write wins the next tie.
        do_reset();
        push_frame(1, 4, 200);
        push_frame(0, 12, 300);
        add_exp(1, 4, 200);
        add_exp(0, 12, 300);
        wait_got("s2", 16, 60);
        cmp_seq("s2");
        got_q.delete(); exp_q.delete();
        wr_q.push_back(mk(1, 1, 1, 210));
        rd_q.push_back(mk(1, 1, 0, 320));
        exp_q.push_back(mk(1, 1, 1, 210));
        exp_q.push_back(mk(1, 1, 0, 320));
        wait_got("s2_tie", 2, 20);
        cmp_seq("s2_tie");

        // Read frame under toggling downstream ready.
        do_reset();
        rmode = 1;
        push_frame(0, 8, 400);
        add_exp(0, 8, 400);
        wait_got("s3", 8, 60);
        cmp_seq("s3");

        // mc_en dropped mid write frame with a read pending.
        do_reset();
        push_frame(1, 8, 500);
        rd_q.push_back(mk(1, 1, 0, 600));
        add_exp(1, 8, 500);
        for (int k = 0; k < 20 && wr_cnt < 3; k++) step();
        chk("s4_reach_beat3", wr_cnt, 3);
        mc_en = 1'b0;
        for (int k = 0; k < 20 && wr_q.size() > 0; k++) step();
        for (int k = 0; k < 5; k++) step();
        chk("s4_rd_pending", rd_q.size(), 1);
        cmp_seq("s4_wr");
        mc_en = 1'b1;
        exp_q.push_back(mk(1, 1, 0, 600));
        wait_got("s4_all", 9, 20);
        cmp_seq("s4_all");

        // Protocol errors on the write port: rw=0 beat, then sof mid-frame.
        do_reset();
        #1;
        chk("s5_err_init", arb_proto_err, 0);
        wr_q.push_back(mk(1, 0, 0, 900)); exp_q.push_back(mk(1, 0, 0, 900));
        wr_q.push_back(mk(0, 0, 1, 901)); exp_q.push_back(mk(0, 0, 1, 901));
        wr_q.push_back(mk(1, 0, 1, 902)); exp_q.push_back(mk(1, 0, 1, 902));
        wr_q.push_back(mk(0, 1, 1, 903)); exp_q.push_back(mk(0, 1, 1, 903));
        step();
        #1;
        chk("s5_err_after_rw", arb_proto_err, 1);
        wait_got("s5", 4, 20);
        cmp_seq("s5");
        chk("s5_err_sticky", arb_proto_err, 1);

        // Reset pulse at read beat 5 of 12, then a fresh single-beat frame.
        do_reset();
        push_frame(0, 12, 700);
        for (int k = 0; k < 20 && rd_cnt < 5; k++) step();
        chk("s6_reach_beat5", rd_cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_vld", axi2array_frame_valid, 0);
        chk("s6_dat", axi2array_frame_data, 0);
        chk("s6_owner", arb_owner, 0);
        chk("s6_err", arb_proto_err, 0);
        chk("s6_rdy", {wr_frame_ready, rd_frame_ready}, 0);
        clear_model();
        wr_frame_valid = 1'b0;
        rd_frame_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_q.push_back(mk(1, 1, 1, 800));
        exp_q.push_back(mk(1, 1, 1, 800));
        wait_got("s6_fresh", 1, 10);
        for (int k = 0; k < 4; k++) step();
        cmp_seq("s6_fresh");
        chk("s6_owner_end", arb_owner, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
